// File: rtl/pixel_plot_buffer.sv
// First-word-fall-through pixel FIFO between the Mandelbrot generator and the VGA adapter.
// Rejects out-of-range coordinates, flags lost pixels and pulses frame_done once per drained frame.
module pixel_plot_buffer #(
    parameter int DEPTH        = 8,
    parameter int XMAX         = 320,
    parameter int YMAX         = 240,
    parameter int FRAME_PIXELS = 76800
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic [8:0]               in_x,
    input  logic [7:0]               in_y,
    input  logic [2:0]               in_colour,
    input  logic                     in_plot,
    output logic                     in_ready,
    output logic [8:0]               out_x,
    output logic [7:0]               out_y,
    output logic [2:0]               out_colour,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     frame_done,
    output logic                     overflow,
    output logic                     range_err
);

    localparam int              AW    = $clog2(DEPTH);
    localparam int              LW    = AW + 1;
    localparam logic [LW-1:0]   FULL  = LW'(DEPTH);
    localparam logic [9:0]      X_LIM = 10'(XMAX);
    localparam logic [8:0]      Y_LIM = 9'(YMAX);
    localparam logic [16:0]     LAST  = 17'(FRAME_PIXELS - 1);

    logic [19:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [16:0]   pix_cnt;
    logic          in_range;
    logic          push;
    logic          pop;

    assign in_ready  = (level != FULL);
    assign out_valid = (level != '0);
    assign in_range  = ({1'b0, in_x} < X_LIM) && ({1'b0, in_y} < Y_LIM);
    assign push      = in_plot && in_ready && in_range && !clear;
    assign pop       = out_valid && out_ready && !clear;

    // Head is presented straight from storage so a pixel shows up right after its push edge.
    assign {out_x, out_y, out_colour} = out_valid ? mem[rd_ptr] : 20'd0;

    // Storage has no reset; level and pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_x, in_y, in_colour};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            pix_cnt    <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
            range_err  <= 1'b0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            pix_cnt    <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
            range_err  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase

            frame_done <= 1'b0;
            if (pop) begin
                if (pix_cnt == LAST) begin
                    pix_cnt    <= '0;
                    frame_done <= 1'b1;
                end else begin
                    pix_cnt <= pix_cnt + 17'd1;
                end
            end

            if (in_plot && !in_ready) begin
                overflow <= 1'b1;
            end
            if (in_plot && !in_range) begin
                range_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pixel_plot_buffer.sv
// Bench for pixel_plot_buffer: explicit vector table, queue scoreboard and multi-cycle corner sequences.
module tb_pixel_plot_buffer;

    localparam int DEPTH = 8;
    localparam int XMAX  = 320;
    localparam int YMAX  = 240;
    localparam int FRAME = 76800;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic [8:0] in_x = '0;
    logic [7:0] in_y = '0;
    logic [2:0] in_colour = '0;
    logic       in_plot = 1'b0;
    logic       in_ready;
    logic [8:0] out_x;
    logic [7:0] out_y;
    logic [2:0] out_colour;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] level;
    logic       frame_done;
    logic       overflow;
    logic       range_err;

    pixel_plot_buffer #(
        .DEPTH(DEPTH), .XMAX(XMAX), .YMAX(YMAX), .FRAME_PIXELS(FRAME)
    ) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_x(in_x), .in_y(in_y), .in_colour(in_colour), .in_plot(in_plot),
        .in_ready(in_ready),
        .out_x(out_x), .out_y(out_y), .out_colour(out_colour),
        .out_valid(out_valid), .out_ready(out_ready),
        .level(level), .frame_done(frame_done),
        .overflow(overflow), .range_err(range_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [19:0] q[$];
    int m_cnt = 0;
    int m_pops = 0;
    bit m_ovf = 0;
    bit m_rng = 0;
    bit m_fd = 0;
    int fd_seen = 0;
    int fd_at = -1;

    typedef struct {
        bit plot; int x; int y; int c; bit ordy; bit clr;
        int e_level; bit e_rng; int e_ox;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic [19:0] head;
        head = (q.size() != 0) ? q[0] : 20'd0;
        chk("level", int'(level), q.size());
        chk("out_valid", int'(out_valid), int'(q.size() != 0));
        chk("in_ready", int'(in_ready), int'(q.size() != DEPTH));
        chk("out_pixel", int'({out_x, out_y, out_colour}), int'(head));
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("range_err", int'(range_err), int'(m_rng));
        chk("frame_done", int'(frame_done), int'(m_fd));
    endtask

    task automatic reset_model();
        q.delete();
        m_cnt = 0; m_pops = 0; m_ovf = 0; m_rng = 0; m_fd = 0;
    endtask

    // Drive one cycle's inputs, let one edge pass, update the model and compare.
    task automatic cycle(input bit plot, input int x, input int y, input int c,
                         input bit ordy, input bit clr);
        bit inr, rng, push, pop;
        logic [8:0] xv;
        logic [7:0] yv;
        logic [2:0] cv;
        xv = x[8:0]; yv = y[7:0]; cv = c[2:0];
        in_plot = plot; in_x = xv; in_y = yv; in_colour = cv;
        out_ready = ordy; clear = clr;
        inr  = (q.size() != DEPTH);
        rng  = (x < XMAX) && (y < YMAX);
        push = plot && inr && rng && !clr;
        pop  = (q.size() != 0) && ordy && !clr;
        @(posedge clk);
        #1;
        if (clr) begin
            reset_model();
        end else begin
            if (plot && !inr) m_ovf = 1;
            if (plot && !rng) m_rng = 1;
            m_fd = 0;
            if (pop) begin
                void'(q.pop_front());
                m_pops++;
                if (m_cnt == FRAME - 1) begin
                    m_cnt = 0;
                    m_fd = 1;
                end else begin
                    m_cnt++;
                end
            end
            if (push) q.push_back({xv, yv, cv});
        end
        if (frame_done) begin
            fd_seen++;
            fd_at = m_pops;
        end
        check_outputs();
        in_plot = 0; clear = 0;
    endtask

    vec_t vt[$];

    initial begin
        vt.push_back('{1, 5, 7, 3, 0, 0, 1, 0, 5});
        vt.push_back('{1, 6, 7, 1, 0, 0, 2, 0, 5});
        vt.push_back('{1, 7, 7, 2, 0, 0, 3, 0, 5});
        vt.push_back('{0, 0, 0, 0, 1, 0, 2, 0, 6});
        vt.push_back('{0, 0, 0, 0, 1, 0, 1, 0, 7});
        vt.push_back('{0, 0, 0, 0, 1, 0, 0, 0, 0});
        vt.push_back('{1, 320, 0, 1, 0, 0, 0, 1, 0});
        vt.push_back('{1, 0, 240, 1, 0, 0, 0, 1, 0});
        vt.push_back('{0, 0, 0, 0, 0, 1, 0, 0, 0});

        // Reset state
        #12;
        check_outputs();
        rst = 0;

        // Vector table: ordering, drain, range rejection, clear
        foreach (vt[i]) begin
            cycle(vt[i].plot, vt[i].x, vt[i].y, vt[i].c, vt[i].ordy, vt[i].clr);
            chk("vec_level", int'(level), vt[i].e_level);
            chk("vec_range_err", int'(range_err), int'(vt[i].e_rng));
            chk("vec_out_x", int'(out_x), vt[i].e_ox);
        end

        // Nine pushes into an 8-deep buffer with the sink stalled
        for (int i = 0; i < 9; i++) begin
            cycle(1, 10 + i, 20, i % 8, 0, 0);
            if (i == 7) chk("full_in_ready", int'(in_ready), 0);
        end
        chk("ovf_sticky", int'(overflow), 1);
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 1, 0);
        chk("drain_empty", int'(level), 0);
        chk("ovf_held", int'(overflow), 1);

        // Full buffer: push and pop in the same cycle
        cycle(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++) cycle(1, 30 + i, 40, 1, 0, 0);
        cycle(1, 99, 99, 7, 1, 0);
        chk("full_pp_level", int'(level), 7);
        cycle(1, 100, 100, 6, 0, 0);
        chk("refill_level", int'(level), 8);
        for (int i = 0; i < 9; i++) cycle(0, 0, 0, 0, 1, 0);

        // Asynchronous reset between edges with four pixels buffered
        cycle(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) cycle(1, 50 + i, 60, 2, 0, 0);
        chk("pre_rst_level", int'(level), 4);
        #2 rst = 1;
        #1;
        reset_model();
        chk("async_out_valid", int'(out_valid), 0);
        chk("async_level", int'(level), 0);
        chk("async_in_ready", int'(in_ready), 1);
        chk("async_out_x", int'(out_x), 0);
        #2 rst = 0;
        cycle(1, 3, 4, 5, 0, 0);
        chk("first_push_after_rst", int'(level), 1);

        // Part of a frame, clear mid-frame, then a whole frame
        for (int i = 0; i < 1000; i++) cycle(1, i % XMAX, i / XMAX, i % 8, 1, 0);
        cycle(0, 0, 0, 0, 1, 1);
        chk("clear_level", int'(level), 0);
        fd_seen = 0;
        fd_at = -1;
        for (int i = 0; i < FRAME; i++) cycle(1, i % XMAX, (i / XMAX) % YMAX, i % 8, 1, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1, 0);
        chk("frame_pulses", fd_seen, 1);
        chk("frame_pulse_pop", fd_at, FRAME);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
